// File: rtl/trig_fire_gen.sv
// Masked coincidence trigger (OR / AND / majority) with prescaler and re-arm.
// Emits a fixed-width firing pulse on masked outputs, then a dead time; also counters and LED heartbeat.
module trig_fire_gen #(
    parameter int unsigned NIN    = 16,
    parameter int unsigned NOUT   = 16,
    parameter int unsigned CW     = 8,
    parameter int unsigned HB_DIV = 100000000
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [NIN-1:0]             coax_in,
    input  logic [NIN-1:0]             in_mask,
    input  logic [1:0]                 mode,
    input  logic [$clog2(NIN+1)-1:0]   majn,
    input  logic [CW-1:0]              firingticks,
    input  logic [CW-1:0]              deadticks,
    input  logic [CW-1:0]              prescale,
    input  logic [NOUT-1:0]            out_mask,
    output logic [NOUT-1:0]            coax_out,
    output logic                       busy,
    output logic [31:0]                trig_count,
    output logic [31:0]                rej_count,
    output logic [3:0]                 led
);

    localparam int unsigned PW  = $clog2(NIN + 1);
    localparam int unsigned TW  = CW + 3;
    localparam int unsigned HBW = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;

    typedef enum logic [1:0] {
        ST_READY  = 2'd0,
        ST_FIRING = 2'd1,
        ST_DEAD   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [NIN-1:0]  in_q;
    logic            armed_q, armed_d;
    logic [CW-1:0]   pscnt_q, pscnt_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [CW-1:0]   fire_sh_q, fire_sh_d;
    logic [CW-1:0]   dead_sh_q, dead_sh_d;
    logic [NOUT-1:0] omask_sh_q, omask_sh_d;
    logic [NOUT-1:0] coax_out_q, coax_out_d;
    logic            busy_q, busy_d;
    logic [31:0]     trig_q, trig_d;
    logic [31:0]     rej_q, rej_d;
    logic [3:0]      led_q, led_d;
    logic [HBW-1:0]  hb_q, hb_d;

    logic [NIN-1:0]  m_c;
    logic [PW-1:0]   pop_c;
    logic            cond_c;

    // Coincidence condition over the registered inputs
    always_comb begin
        m_c   = in_q & in_mask;
        pop_c = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            pop_c = pop_c + PW'(m_c[i]);
        end
        case (mode)
            2'd0:    cond_c = |m_c;
            2'd1:    cond_c = (m_c == in_mask) && (in_mask != '0);
            2'd2:    cond_c = (pop_c >= majn) && (majn != '0);
            default: cond_c = 1'b0;
        endcase
    end

    // Next-state: trigger FSM, prescaler, shadow config, counters
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        pscnt_d    = pscnt_q;
        tick_d     = tick_q;
        fire_sh_d  = fire_sh_q;
        dead_sh_d  = dead_sh_q;
        omask_sh_d = omask_sh_q;
        coax_out_d = coax_out_q;
        trig_d     = trig_q;
        rej_d      = rej_q;
        case (state_q)
            ST_READY: begin
                if (!cond_c) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    if (pscnt_q == prescale) begin
                        state_d    = ST_FIRING;
                        pscnt_d    = '0;
                        tick_d     = '0;
                        trig_d     = trig_q + 32'd1;
                        fire_sh_d  = firingticks;
                        dead_sh_d  = deadticks;
                        omask_sh_d = out_mask;
                        coax_out_d = out_mask;
                    end else begin
                        pscnt_d = pscnt_q + CW'(1);
                        rej_d   = rej_q + 32'd1;
                    end
                end
            end
            ST_FIRING: begin
                if (tick_q == TW'(fire_sh_q)) begin
                    state_d    = ST_DEAD;
                    tick_d     = '0;
                    coax_out_d = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            ST_DEAD: begin
                // deadticks*4+1 cycles: tick runs 0 .. deadticks*4
                if (tick_q == {1'b0, dead_sh_q, 2'b00}) begin
                    state_d = ST_READY;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d    = ST_READY;
                tick_d     = '0;
                coax_out_d = '0;
            end
        endcase
        busy_d = (state_d == ST_FIRING) || (state_d == ST_DEAD);
    end

    // LED heartbeat: rotate the single zero every HB_DIV cycles
    always_comb begin
        hb_d  = hb_q + HBW'(1);
        led_d = led_q;
        if (hb_q == HBW'(HB_DIV - 1)) begin
            hb_d  = '0;
            led_d = {led_q[2:0], led_q[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= ST_READY;
            in_q       <= '0;
            armed_q    <= 1'b1;
            pscnt_q    <= '0;
            tick_q     <= '0;
            fire_sh_q  <= '0;
            dead_sh_q  <= '0;
            omask_sh_q <= '0;
            coax_out_q <= '0;
            busy_q     <= 1'b0;
            trig_q     <= '0;
            rej_q      <= '0;
            led_q      <= 4'b1110;
            hb_q       <= '0;
        end else begin
            state_q    <= state_d;
            in_q       <= coax_in;
            armed_q    <= armed_d;
            pscnt_q    <= pscnt_d;
            tick_q     <= tick_d;
            fire_sh_q  <= fire_sh_d;
            dead_sh_q  <= dead_sh_d;
            omask_sh_q <= omask_sh_d;
            coax_out_q <= coax_out_d;
            busy_q     <= busy_d;
            trig_q     <= trig_d;
            rej_q      <= rej_d;
            led_q      <= led_d;
            hb_q       <= hb_d;
        end
    end

    assign coax_out   = coax_out_q;
    assign busy       = busy_q;
    assign trig_count = trig_q;
    assign rej_count  = rej_q;
    assign led        = led_q;

endmodule

// File: tb/tb_trig_fire_gen.sv
// Directed bench for trig_fire_gen: coincidence modes, pulse/dead timing, re-arm, prescale, config shadowing, reset, LED.
module tb_trig_fire_gen;

    logic        clk;
    logic        nrst;
    logic [15:0] coax_in;
    logic [15:0] in_mask;
    logic [1:0]  mode;
    logic [4:0]  majn;
    logic [7:0]  firingticks;
    logic [7:0]  deadticks;
    logic [7:0]  prescale;
    logic [15:0] out_mask;
    logic [15:0] coax_out;
    logic        busy;
    logic [31:0] trig_count;
    logic [31:0] rej_count;
    logic [3:0]  led;

    int          n_checks;
    int          n_errors;
    logic [7:0]  nxt_ft;
    logic [15:0] nxt_om;

    trig_fire_gen #(
        .NIN(16), .NOUT(16), .CW(8), .HB_DIV(4)
    ) dut (
        .clk(clk), .nrst(nrst), .coax_in(coax_in), .in_mask(in_mask), .mode(mode),
        .majn(majn), .firingticks(firingticks), .deadticks(deadticks), .prescale(prescale),
        .out_mask(out_mask), .coax_out(coax_out), .busy(busy), .trig_count(trig_count),
        .rej_count(rej_count), .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive bits from this negedge, drop after `hold` cycles, observe for `win` negedges.
    // Optionally swap firingticks/out_mask at negedge `chg_at` (0 = never).
    task automatic pulse(input logic [15:0] bits, input int hold, input int win, input int chg_at,
                         output int lat, output int nfire, output int nbusy, output logic [15:0] val);
        lat = -1; nfire = 0; nbusy = 0; val = '0;
        coax_in = bits;
        for (int i = 1; i <= win; i++) begin
            @(negedge clk);
            if (i == hold) coax_in = '0;
            if (i == chg_at) begin
                firingticks = nxt_ft;
                out_mask    = nxt_om;
            end
            if (coax_out != '0) begin
                if (lat < 0) begin
                    lat = i;
                    val = coax_out;
                end
                nfire++;
            end
            if (busy) nbusy++;
        end
    endtask

    initial begin
        int lat, nf, nb, tr0, rj0;
        logic [15:0] v;
        logic [8:0]  fired;
        n_checks = 0; n_errors = 0;
        nrst = 1'b0; coax_in = '0; in_mask = 16'h0300; mode = 2'd0; majn = 5'd0;
        firingticks = 8'd3; deadticks = 8'd2; prescale = 8'd0; out_mask = 16'hA5A5;
        nxt_ft = '0; nxt_om = '0;
        repeat (3) @(negedge clk);
        check("rst_coax_out", 32'(coax_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_trig", trig_count, 32'h0);
        check("rst_rej", rej_count, 32'h0);
        check("rst_led", 32'(led), 32'hE);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // OR mode, masked input 8 fires, input 0 masked off
        pulse(16'h0100, 1, 30, 0, lat, nf, nb, v);
        check("or_latency", 32'(lat), 32'd2);
        check("or_width", 32'(nf), 32'd4);
        check("or_busy", 32'(nb), 32'd13);
        check("or_value", 32'(v), 32'hA5A5);
        check("or_trig", trig_count, 32'd1);
        pulse(16'h0001, 1, 20, 0, lat, nf, nb, v);
        check("or_masked_nofire", 32'(nf), 32'd0);
        check("or_masked_nobusy", 32'(nb), 32'd0);

        // Majority 3 of 4
        mode = 2'd2; majn = 5'd3; in_mask = 16'h000F;
        pulse(16'h0003, 1, 20, 0, lat, nf, nb, v);
        check("maj_2of4", 32'(nf), 32'd0);
        pulse(16'h0007, 1, 30, 0, lat, nf, nb, v);
        check("maj_3of4", 32'(nf), 32'd4);
        check("maj_trig", trig_count, 32'd2);

        // AND mode: empty mask never fires, full match fires
        mode = 2'd1; in_mask = 16'h0000;
        pulse(16'hFFFF, 1, 20, 0, lat, nf, nb, v);
        check("and_empty_mask", 32'(nf), 32'd0);
        in_mask = 16'h0003;
        pulse(16'h0001, 1, 20, 0, lat, nf, nb, v);
        check("and_partial", 32'(nf), 32'd0);
        pulse(16'h0003, 1, 30, 0, lat, nf, nb, v);
        check("and_full", 32'(nf), 32'd4);
        mode = 2'd3; in_mask = 16'hFFFF;
        pulse(16'hFFFF, 1, 20, 0, lat, nf, nb, v);
        check("disabled", 32'(nf), 32'd0);

        // Held condition fires once, re-arms after it drops
        mode = 2'd0; in_mask = 16'h0001; firingticks = 8'd0; deadticks = 8'd1; out_mask = 16'hFFFF;
        pulse(16'h0001, 100, 110, 0, lat, nf, nb, v);
        check("hold_once", 32'(nf), 32'd1);
        check("hold_busy", 32'(nb), 32'd6);
        check("hold_lat", 32'(lat), 32'd2);
        pulse(16'h0001, 1, 12, 0, lat, nf, nb, v);
        check("rearm_fire", 32'(nf), 32'd1);

        // Prescale 2: pulses 3, 6, 9 fire
        prescale = 8'd2; deadticks = 8'd0;
        tr0 = int'(trig_count); rj0 = int'(rej_count); fired = '0;
        for (int k = 0; k < 9; k++) begin
            pulse(16'h0001, 1, 8, 0, lat, nf, nb, v);
            fired[k] = (nf != 0);
        end
        check("ps_pattern", 32'(fired), 32'h124);
        check("ps_trig", trig_count - 32'(tr0), 32'd3);
        check("ps_rej", rej_count - 32'(rj0), 32'd6);
        prescale = 8'd0;

        // Config changed mid-FIRING only applies to the next trigger
        firingticks = 8'd3; out_mask = 16'h00FF; nxt_ft = 8'd10; nxt_om = 16'hFF00;
        pulse(16'h0001, 1, 12, 3, lat, nf, nb, v);
        check("shadow_width_old", 32'(nf), 32'd4);
        check("shadow_mask_old", 32'(v), 32'h00FF);
        pulse(16'h0001, 1, 20, 0, lat, nf, nb, v);
        check("shadow_width_new", 32'(nf), 32'd11);
        check("shadow_mask_new", 32'(v), 32'hFF00);

        // Reset during DEAD
        firingticks = 8'd0; deadticks = 8'd5;
        pulse(16'h0001, 1, 4, 0, lat, nf, nb, v);
        check("pre_rst_busy", 32'(busy), 32'h1);
        nrst = 1'b0;
        @(negedge clk);
        check("rst_dead_coax", 32'(coax_out), 32'h0);
        check("rst_dead_busy", 32'(busy), 32'h0);
        check("rst_dead_trig", trig_count, 32'h0);
        check("rst_dead_rej", rej_count, 32'h0);
        check("rst_dead_led", 32'(led), 32'hE);
        nrst = 1'b1;

        // LED steps every 4 cycles with HB_DIV=4
        repeat (3) @(negedge clk);
        check("led_hold", 32'(led), 32'hE);
        @(negedge clk);
        check("led_step1", 32'(led), 32'hD);
        repeat (4) @(negedge clk);
        check("led_step2", 32'(led), 32'hB);
        repeat (4) @(negedge clk);
        check("led_step3", 32'(led), 32'h7);
        repeat (4) @(negedge clk);
        check("led_wrap", 32'(led), 32'hE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
